cic_dec_sched: RTL

Round-robin scheduler that time-shares one integrate-and-dump (boxcar CIC, order 1) decimation datapath among `N_CH` 10-bit sample streams. Each cycle it grants at most one requesting channel, adds that channel's sample into a per-channel accumulator, and emits a 13-bit decimated sum tagged with its channel number when that channel has been accepted R times. It sits between the ADC front-end channel FIFOs and the downstream CIC compensation stage. The decimation factor R is run-time configurable.

---
 rtl/cic_dec_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cic_dec_sched.sv
// Round-robin shared integrate-and-dump (order-1 CIC) decimator.
// Ports: clk/rst (sync, active-low); per-channel in_valid/in_data/in_ready;
// cfg_we/cfg_dec set R = cfg_dec+1; rdy/dout/dout_ch carry one decimated sum.
module cic_dec_sched #(
  parameter int N_CH    = 4,
  parameter int DW      = 10,
  parameter int OW      = 13,
  parameter int DEF_DEC = 4,
  localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    in_valid,
  input  logic [N_CH*DW-1:0] in_data,
  output logic [N_CH-1:0]    in_ready,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_dec,
  output logic               rdy,
  output logic [OW-1:0]      dout,
  output logic [CW-1:0]      dout_ch
);

  logic [OW-1:0] acc_q [N_CH];
  logic [OW-1:0] acc_d [N_CH];
  logic [2:0]    cnt_q [N_CH];
  logic [2:0]    cnt_d [N_CH];
  logic [2:0]    dec_q, dec_d;
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic          rdy_q, rdy_d;
  logic [OW-1:0] dout_q, dout_d;
  logic [CW-1:0] dout_ch_q, dout_ch_d;

  logic [N_CH-1:0] gnt;
  logic [CW-1:0]   gidx;
  logic            found;
  logic [CW:0]     sum_idx;
  logic [CW-1:0]   cand;
  logic [DW-1:0]   smp;
  logic [OW-1:0]   sext;
  logic [OW-1:0]   sum;
  logic            accept;

  // Scan from rr_ptr upward, wrapping; first valid channel wins.
  always_comb begin
    found   = 1'b0;
    gidx    = '0;
    gnt     = '0;
    sum_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum_idx = {1'b0, rr_ptr_q} + (CW+1)'(i);
      if (sum_idx >= (CW+1)'(N_CH)) begin
        sum_idx = sum_idx - (CW+1)'(N_CH);
      end
      cand = sum_idx[CW-1:0];
      if (!found && in_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    // Config and reset both block acceptance.
    if (found && rst && !cfg_we) begin
      gnt[gidx] = 1'b1;
    end
  end

  assign accept = |gnt;

  always_comb begin
    smp = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gidx == CW'(k)) begin
        smp = in_data[k*DW +: DW];
      end
    end
  end

  assign sext = {{(OW-DW){smp[DW-1]}}, smp};
  assign sum  = acc_q[gidx] + sext;

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dec_d     = dec_q;
    rr_ptr_d  = rr_ptr_q;
    rdy_d     = 1'b0;
    dout_d    = dout_q;
    dout_ch_d = dout_ch_q;
    if (cfg_we) begin
      dec_d    = cfg_dec;
      rr_ptr_d = '0;
      for (int k = 0; k < N_CH; k++) begin
        acc_d[k] = '0;
        cnt_d[k] = '0;
      end
    end else if (accept) begin
      if (cnt_q[gidx] == dec_q) begin
        // R-th sample: dump the frame and restart.
        dout_d      = sum;
        dout_ch_d   = gidx;
        rdy_d       = 1'b1;
        acc_d[gidx] = '0;
        cnt_d[gidx] = '0;
      end else begin
        acc_d[gidx] = sum;
        cnt_d[gidx] = cnt_q[gidx] + 3'd1;
      end
      rr_ptr_d = (gidx == CW'(N_CH-1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N_CH; k++) begin
        acc_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      dec_q     <= 3'(DEF_DEC);
      rr_ptr_q  <= '0;
      rdy_q     <= 1'b0;
      dout_q    <= '0;
      dout_ch_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        acc_q[k] <= acc_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      dec_q     <= dec_d;
      rr_ptr_q  <= rr_ptr_d;
      rdy_q     <= rdy_d;
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
    end
  end

  assign in_ready = gnt;
  assign rdy      = rdy_q;
  assign dout     = dout_q;
  assign dout_ch  = dout_ch_q;

endmodule
